// File: rtl/gt_pll_ctrl_pkg.sv
// rtl/gt_pll_ctrl_pkg.sv - shared state encoding, default timing and width helpers for the GTP common PLL sequencer
package gt_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PWRUP     = 3'd1,
        ST_RESET     = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_STABLE    = 3'd4,
        ST_READY     = 3'd5,
        ST_REFWAIT   = 3'd6,
        ST_FAIL      = 3'd7
    } pll_state_e;

    localparam int DEF_PD_CYCLES     = 256;
    localparam int DEF_RST_CYCLES    = 64;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRY     = 3;

    function automatic int ctr_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    localparam int RETRY_W = $clog2(DEF_MAX_RETRY) + 1;

endpackage

// File: rtl/gt_pll_seq.sv
// rtl/gt_pll_seq.sv - one PLL power-up/reset/lock sequencer with input synchronizers
// GT_PLL_CTRL_STAT_EN builds the 8-bit saturating lock-loss counter; otherwise o_lossc is 0.
module gt_pll_seq
    import gt_pll_ctrl_pkg::*;
#(
    parameter int PD_CYCLES     = DEF_PD_CYCLES,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int RETRY_W       = gt_pll_ctrl_pkg::RETRY_W
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_lock,
    input  logic       i_refclk_lost,
    output logic       o_pd,
    output logic       o_reset,
    output logic       o_ready,
    output logic       o_fail,
    output logic [2:0] o_state,
    output logic [7:0] o_lossc
);

    localparam int MAX_PR = (PD_CYCLES > RST_CYCLES) ? PD_CYCLES : RST_CYCLES;
    localparam int MAX_TS = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int CW     = ctr_width((MAX_PR > MAX_TS) ? MAX_PR : MAX_TS);

    // Loads are N-1 so that the state is visible for exactly N cycles.
    localparam logic [CW-1:0] LD_PD  = CW'(PD_CYCLES - 1);
    localparam logic [CW-1:0] LD_RST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LD_TO  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] LD_STB = CW'(STABLE_CYCLES - 1);

    logic [1:0]         r_lock_sync;
    logic [1:0]         r_ref_sync;
    logic               w_lock;
    logic               w_ref;
    pll_state_e         r_state;
    pll_state_e         w_next;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_next;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_next;
    logic [RETRY_W-1:0] w_retry_inc;
    logic               r_pd;
    logic               r_reset;
    logic               r_ready;
    logic               r_fail;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_sync <= 2'b00;
            r_ref_sync  <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], i_lock};
            r_ref_sync  <= {r_ref_sync[0], i_refclk_lost};
        end
    end

    assign w_lock      = r_lock_sync[1];
    assign w_ref       = r_ref_sync[1];
    assign w_retry_inc = r_retry + RETRY_W'(1);

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_retry_next = r_retry;
        if (!i_en) begin
            w_next       = ST_OFF;
            w_retry_next = '0;
        end else if (w_ref && (r_state inside {ST_RESET, ST_WAIT_LOCK, ST_STABLE, ST_READY})) begin
            w_next = ST_REFWAIT;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_next     = ST_PWRUP;
                    w_cnt_next = LD_PD;
                end
                ST_PWRUP: begin
                    if (r_cnt == '0) begin
                        w_next     = ST_RESET;
                        w_cnt_next = LD_RST;
                    end else begin
                        w_cnt_next = r_cnt - CW'(1);
                    end
                end
                ST_RESET: begin
                    if (r_cnt == '0) begin
                        w_next     = ST_WAIT_LOCK;
                        w_cnt_next = LD_TO;
                    end else begin
                        w_cnt_next = r_cnt - CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is tested first so it wins over a simultaneous timeout.
                    if (w_lock) begin
                        w_next     = ST_STABLE;
                        w_cnt_next = LD_STB;
                    end else if (r_cnt == '0) begin
                        w_retry_next = w_retry_inc;
                        if (w_retry_inc >= RETRY_W'(MAX_RETRY)) begin
                            w_next = ST_FAIL;
                        end else begin
                            w_next     = ST_RESET;
                            w_cnt_next = LD_RST;
                        end
                    end else begin
                        w_cnt_next = r_cnt - CW'(1);
                    end
                end
                ST_STABLE: begin
                    if (!w_lock) begin
                        w_next     = ST_WAIT_LOCK;
                        w_cnt_next = LD_TO;
                    end else if (r_cnt == '0) begin
                        w_next       = ST_READY;
                        w_retry_next = '0;
                    end else begin
                        w_cnt_next = r_cnt - CW'(1);
                    end
                end
                ST_READY: begin
                    if (!w_lock) begin
                        w_next     = ST_RESET;
                        w_cnt_next = LD_RST;
                    end
                end
                ST_REFWAIT: begin
                    if (!w_ref) begin
                        w_next     = ST_RESET;
                        w_cnt_next = LD_RST;
                    end
                end
                ST_FAIL: w_next = ST_FAIL;
                default: w_next = ST_OFF;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_retry <= '0;
            r_pd    <= 1'b1;
            r_reset <= 1'b1;
            r_ready <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_retry <= w_retry_next;
            r_pd    <= (w_next == ST_OFF) || (w_next == ST_FAIL);
            r_reset <= !((w_next == ST_WAIT_LOCK) || (w_next == ST_STABLE) || (w_next == ST_READY));
            r_ready <= (w_next == ST_READY);
            r_fail  <= (w_next == ST_FAIL);
        end
    end

    assign o_pd    = r_pd;
    assign o_reset = r_reset;
    assign o_ready = r_ready;
    assign o_fail  = r_fail;
    assign o_state = r_state;

`ifdef GT_PLL_CTRL_STAT_EN
    logic [7:0] r_lossc;
    logic       w_loss;

    // READY only reaches RESET through a lock drop; refclk loss goes via REFWAIT.
    assign w_loss = (r_state == ST_READY) && (w_next == ST_RESET);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lossc <= 8'h00;
        end else if (w_loss && (r_lossc != 8'hFF)) begin
            r_lossc <= r_lossc + 8'd1;
        end
    end

    assign o_lossc = r_lossc;
`else
    assign o_lossc = 8'h00;
`endif

endmodule

// File: rtl/gt_common_pll_ctrl.sv
// rtl/gt_common_pll_ctrl.sv - GTP common-block PLL0 (PCIe) / PLL1 (SFP) sequencer top
// Lock-loss counters on o_pll_lossc exist only when GT_PLL_CTRL_STAT_EN is defined.
module gt_common_pll_ctrl
    import gt_pll_ctrl_pkg::*;
#(
    parameter int PD_CYCLES     = DEF_PD_CYCLES,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_pll_en,
    input  logic [1:0]  i_pll_lock,
    input  logic [1:0]  i_pll_refclk_lost,
    output logic [1:0]  o_pll_pd,
    output logic [1:0]  o_pll_reset,
    output logic [1:0]  o_pll_ready,
    output logic [1:0]  o_pll_fail,
    output logic [5:0]  o_pll_state,
    output logic [15:0] o_pll_lossc
);

    for (genvar g = 0; g < 2; g++) begin : g_pll
        gt_pll_seq #(
            .PD_CYCLES    (PD_CYCLES),
            .RST_CYCLES   (RST_CYCLES),
            .LOCK_TIMEOUT (LOCK_TIMEOUT),
            .STABLE_CYCLES(STABLE_CYCLES),
            .MAX_RETRY    (MAX_RETRY),
            .RETRY_W      (ctr_width(MAX_RETRY))
        ) u_seq (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_en         (i_pll_en[g]),
            .i_lock       (i_pll_lock[g]),
            .i_refclk_lost(i_pll_refclk_lost[g]),
            .o_pd         (o_pll_pd[g]),
            .o_reset      (o_pll_reset[g]),
            .o_ready      (o_pll_ready[g]),
            .o_fail       (o_pll_fail[g]),
            .o_state      (o_pll_state[3*g +: 3]),
            .o_lossc      (o_pll_lossc[8*g +: 8])
        );
    end

endmodule

// File: tb/tb_gt_common_pll_ctrl.sv
// tb/tb_gt_common_pll_ctrl.sv - scoreboard bench for gt_common_pll_ctrl against a scenario-level timing model
module tb_gt_common_pll_ctrl;

    localparam int PD  = 4;
    localparam int RST = 8;
    localparam int TO  = 100;
    localparam int STB = 16;
    localparam int MR  = 2;

    localparam logic [2:0] S_OFF = 3'd0, S_PWRUP = 3'd1, S_RESET = 3'd2, S_WAIT = 3'd3;
    localparam logic [2:0] S_STABLE = 3'd4, S_READY = 3'd5, S_REFWAIT = 3'd6, S_FAIL = 3'd7;

`ifdef GT_PLL_CTRL_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  en = 2'b00;
    logic [1:0]  lock = 2'b00;
    logic [1:0]  refl = 2'b00;
    logic [1:0]  o_pll_pd, o_pll_reset, o_pll_ready, o_pll_fail;
    logic [5:0]  o_pll_state;
    logic [15:0] o_pll_lossc;

    gt_common_pll_ctrl #(
        .PD_CYCLES(PD), .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STB), .MAX_RETRY(MR)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pll_en(en), .i_pll_lock(lock), .i_pll_refclk_lost(refl),
        .o_pll_pd(o_pll_pd), .o_pll_reset(o_pll_reset), .o_pll_ready(o_pll_ready),
        .o_pll_fail(o_pll_fail), .o_pll_state(o_pll_state), .o_pll_lossc(o_pll_lossc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [14:0] t;
    } ev_t;

    ev_t         q0[$];
    ev_t         q1[$];
    int          total = 0;
    int          bad = 0;
    int          nloss[2];
    logic [14:0] last[2];
    logic [14:0] prev[2];
    bit          mon_on = 1'b0;

    // Visible outputs implied by a state, straight from the state table.
    function automatic logic [14:0] tup(input logic [2:0] st, input int n);
        logic       pd, rs, rd, fl;
        logic [7:0] lc;
        pd = (st == S_OFF) || (st == S_FAIL);
        rs = !((st == S_WAIT) || (st == S_STABLE) || (st == S_READY));
        rd = (st == S_READY);
        fl = (st == S_FAIL);
        lc = (n > 255) ? 8'hFF : 8'(n);
        if (!STAT) lc = 8'h00;
        return {st, pd, rs, rd, fl, lc};
    endfunction

    function automatic logic [14:0] cur(input int p);
        if (p == 0)
            return {o_pll_state[2:0], o_pll_pd[0], o_pll_reset[0], o_pll_ready[0], o_pll_fail[0], o_pll_lossc[7:0]};
        return {o_pll_state[5:3], o_pll_pd[1], o_pll_reset[1], o_pll_ready[1], o_pll_fail[1], o_pll_lossc[15:8]};
    endfunction

    task automatic expect_ev(input int p, input int c, input logic [2:0] st);
        ev_t e;
        e.c = c;
        e.t = tup(st, nloss[p]);
        if (e.t == last[p]) return;
        last[p] = e.t;
        if (p == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [14:0] got;
        ev_t         e;
        if (mon_on) begin
            for (int p = 0; p < 2; p++) begin
                got = cur(p);
                if (got !== prev[p]) begin
                    prev[p] = got;
                    total++;
                    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                        bad++;
                        $display("FAIL unexpected_ev pll%0d cyc=%0d got=%h want=none", p, cyc, got);
                    end else begin
                        e = (p == 0) ? q0.pop_front() : q1.pop_front();
                        if (e.c != cyc || e.t !== got) begin
                            bad++;
                            $display("FAIL ev_pll%0d got cyc=%0d tup=%h want cyc=%0d tup=%h", p, cyc, got, e.c, e.t);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic start_pll(input int p, output int w);
        int n;
        n = cyc;
        en[p] = 1'b1;
        expect_ev(p, n + 1, S_PWRUP);
        expect_ev(p, n + 1 + PD, S_RESET);
        w = n + 1 + PD + RST;
        expect_ev(p, w, S_WAIT);
    endtask

    task automatic stop_pll(input int p);
        en[p] = 1'b0;
        lock[p] = 1'b0;
        expect_ev(p, cyc + 1, S_OFF);
        tick(4);
    endtask

    initial begin : stim
        int w, w2, w3, s, d, k, r, rdy, dl, ll, c;
        nloss[0] = 0;
        nloss[1] = 0;
        #2 rst_n = 1'b0;
        tick(2);
        chk("rst_pd", 16'(o_pll_pd), 16'h0003);
        chk("rst_reset", 16'(o_pll_reset), 16'h0003);
        chk("rst_ready", 16'(o_pll_ready), 16'h0000);
        chk("rst_fail", 16'(o_pll_fail), 16'h0000);
        chk("rst_state", 16'(o_pll_state), 16'h0000);
        chk("rst_lossc", o_pll_lossc, 16'h0000);
        for (int p = 0; p < 2; p++) begin
            last[p] = tup(S_OFF, 0);
            prev[p] = tup(S_OFF, 0);
        end
        mon_on = 1'b1;
        rst_n = 1'b1;
        tick(3);

        // nominal lock with the first run 10 cycles after reset falls
        for (int i = 0; i < 3; i++) begin
            d = (i == 0) ? 10 : int'($urandom_range(1, 90));
            start_pll(0, w);
            wait_cyc(w + d);
            lock[0] = 1'b1;
            s = w + d + 3;
            expect_ev(0, s, S_STABLE);
            expect_ev(0, s + STB, S_READY);
            wait_cyc(s + STB + 4);
            stop_pll(0);
        end

        // timeouts until FAIL, then restart with a cleared retry count
        start_pll(0, w);
        expect_ev(0, w + TO, S_RESET);
        w2 = w + TO + RST;
        expect_ev(0, w2, S_WAIT);
        expect_ev(0, w2 + TO, S_FAIL);
        wait_cyc(w2 + TO + 5);
        stop_pll(0);
        start_pll(0, w);
        expect_ev(0, w + TO, S_RESET);
        w2 = w + TO + RST;
        expect_ev(0, w2, S_WAIT);
        d = $urandom_range(1, 60);
        wait_cyc(w2 + d);
        lock[0] = 1'b1;
        expect_ev(0, w2 + d + 3, S_STABLE);
        expect_ev(0, w2 + d + 3 + STB, S_READY);
        wait_cyc(w2 + d + 3 + STB + 3);
        stop_pll(0);

        // 3-cycle lock bounce inside STABLE
        for (int i = 0; i < 3; i++) begin
            start_pll(0, w);
            d = $urandom_range(1, 60);
            wait_cyc(w + d);
            lock[0] = 1'b1;
            s = w + d + 3;
            expect_ev(0, s, S_STABLE);
            k = (i == 0) ? 9 : int'($urandom_range(0, 12));
            dl = s + k;
            expect_ev(0, dl + 3, S_WAIT);
            expect_ev(0, dl + 6, S_STABLE);
            expect_ev(0, dl + 6 + STB, S_READY);
            wait_cyc(dl);
            lock[0] = 1'b0;
            tick(3);
            lock[0] = 1'b1;
            wait_cyc(dl + 6 + STB + 3);
            stop_pll(0);
        end

        // refclk loss in WAIT_LOCK after one timeout: retry count must survive it
        start_pll(0, w);
        expect_ev(0, w + TO, S_RESET);
        w2 = w + TO + RST;
        expect_ev(0, w2, S_WAIT);
        r = w2 + int'($urandom_range(5, 60));
        expect_ev(0, r + 3, S_REFWAIT);
        expect_ev(0, r + 23, S_RESET);
        w3 = r + 23 + RST;
        expect_ev(0, w3, S_WAIT);
        expect_ev(0, w3 + TO, S_FAIL);
        wait_cyc(r);
        refl[0] = 1'b1;
        tick(20);
        refl[0] = 1'b0;
        wait_cyc(w3 + TO + 3);
        stop_pll(0);

        // repeated lock loss in READY on PLL1, past lossc saturation
        lock[1] = 1'b1;
        tick(3);
        start_pll(1, w);
        expect_ev(1, w + 1, S_STABLE);
        rdy = w + 1 + STB;
        expect_ev(1, rdy, S_READY);
        for (int i = 0; i < 300; i++) begin
            dl = rdy + int'($urandom_range(0, 4));
            ll = $urandom_range(1, 3);
            nloss[1]++;
            expect_ev(1, dl + 3, S_RESET);
            expect_ev(1, dl + 3 + RST, S_WAIT);
            expect_ev(1, dl + 4 + RST, S_STABLE);
            rdy = dl + 4 + RST + STB;
            expect_ev(1, rdy, S_READY);
            wait_cyc(dl);
            lock[1] = 1'b0;
            tick(ll);
            lock[1] = 1'b1;
        end
        wait_cyc(rdy + 3);
        chk("lossc1_sat", 16'(o_pll_lossc[15:8]), STAT ? 16'h00FF : 16'h0000);
        stop_pll(1);

        // async reset while PLL0 is in STABLE
        start_pll(0, w);
        wait_cyc(w + 5);
        lock[0] = 1'b1;
        s = w + 8;
        expect_ev(0, s, S_STABLE);
        wait_cyc(s + 5);
        nloss[0] = 0;
        nloss[1] = 0;
        expect_ev(0, cyc, S_OFF);
        expect_ev(1, cyc, S_OFF);
        rst_n = 1'b0;
        #1;
        chk("arst_pd", 16'(o_pll_pd), 16'h0003);
        chk("arst_reset", 16'(o_pll_reset), 16'h0003);
        chk("arst_ready", 16'(o_pll_ready), 16'h0000);
        chk("arst_state", 16'(o_pll_state), 16'h0000);
        chk("arst_lossc", o_pll_lossc, 16'h0000);
        tick(3);
        rst_n = 1'b1;
        c = cyc;
        expect_ev(0, c + 1, S_PWRUP);
        expect_ev(0, c + 1 + PD, S_RESET);
        expect_ev(0, c + 1 + PD + RST, S_WAIT);
        expect_ev(0, c + 2 + PD + RST, S_STABLE);
        expect_ev(0, c + 2 + PD + RST + STB, S_READY);
        wait_cyc(c + 2 + PD + RST + STB + 3);
        stop_pll(0);

        tick(5);
        chk("q0_drained", 16'(q0.size()), 16'h0000);
        chk("q1_drained", 16'(q1.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        total++;
        bad++;
        $display("FAIL watchdog cyc=%0d limit=200000", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
